seq_detector_fsm: RTL and testbench



---
 rtl/seq_detector_fsm.sv | 72 +++++++
 tb/tb_seq_detector_fsm.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_fsm.sv
// Moore detector for the serial pattern 1011; detector pulses one cycle after the last bit.
// Define SEQ_DET_COUNT_EN to add the saturating match_count output.
module seq_detector_fsm #(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             seq,
`ifdef SEQ_DET_COUNT_EN
    output logic [CNT_W-1:0] match_count,
`endif
    output logic             detector
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_e;

    state_e state_q, state_d;

    // Elaboration-time sanity checks on the configuration.
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_detector_fsm: CNT_W must be >= 1");
    end
    if (OVERLAP != 0 && OVERLAP != 1) begin : g_bad_overlap
        $error("seq_detector_fsm: OVERLAP must be 0 or 1");
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE:  state_d = seq ? S1    : IDLE;
            S1:    state_d = seq ? S1    : S10;
            S10:   state_d = seq ? S101  : IDLE;
            S101:  state_d = seq ? S1011 : S10;
            // Without overlap a trailing 0 cannot reuse the match's final 1.
            S1011: state_d = seq ? S1 : ((OVERLAP != 0) ? S10 : IDLE);
            default: state_d = IDLE;
        endcase
    end

    assign detector = (state_q == S1011);

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // S1011 never self-loops, so next-state S1011 marks exactly one entry.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == S1011 && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detector_fsm.sv
// Scoreboard bench: two detectors (overlap on/off) fed the same stream, checked
// against a sliding-window reference model of the 1011 match rules.
module tb_seq_detector_fsm;

    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk, rstn, seq;
    logic det1, det0;
`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] mc1, mc0;
`endif

    seq_detector_fsm #(.OVERLAP(1), .CNT_W(CNT_W)) u_ov (
        .clk(clk), .rstn(rstn), .seq(seq),
`ifdef SEQ_DET_COUNT_EN
        .match_count(mc1),
`endif
        .detector(det1)
    );

    seq_detector_fsm #(.OVERLAP(0), .CNT_W(CNT_W)) u_nov (
        .clk(clk), .rstn(rstn), .seq(seq),
`ifdef SEQ_DET_COUNT_EN
        .match_count(mc0),
`endif
        .detector(det0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit d1;
        bit d0;
        int c1;
        int c0;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a match is the last four bits (since reset) reading 1011.
    // Without overlap the bit history is also discarded after each match.
    bit [3:0] w1, w0;
    int       n1, n0, c1, c0;

    task automatic model_reset();
        w1 = '0; w0 = '0; n1 = 0; n0 = 0; c1 = 0; c0 = 0;
    endtask

    task automatic drive_bit(input bit b, input bit r);
        exp_t e;
        @(negedge clk);
        rstn = r;
        seq  = b;
        if (!r) begin
            model_reset();
            e = '{d1: 1'b0, d0: 1'b0, c1: 0, c0: 0};
        end else begin
            w1 = {w1[2:0], b}; n1++;
            w0 = {w0[2:0], b}; n0++;
            e.d1 = (n1 >= 4) && (w1 == 4'b1011);
            e.d0 = (n0 >= 4) && (w0 == 4'b1011);
            if (e.d0) n0 = 0;
            if (e.d1 && c1 < CMAX) c1++;
            if (e.d0 && c0 < CMAX) c0++;
            e.c1 = c1;
            e.c0 = c0;
        end
        exp_q.push_back(e);
    endtask

    task automatic drive_str(input string s);
        for (int i = 0; i < s.len(); i++) drive_bit(s[i] == "1", 1'b1);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) drive_bit(i[0], 1'b0);
    endtask

    // Monitor: one expected response per clock edge, sampled just after it.
    initial begin
        exp_t e;
        bit   p1, p0;
        p1 = 1'b0; p0 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("det_overlap", int'(det1), int'(e.d1));
                chk("det_no_overlap", int'(det0), int'(e.d0));
                chk("no_consec_pulse", int'(p1 & det1) + int'(p0 & det0), 0);
`ifdef SEQ_DET_COUNT_EN
                chk("count_overlap", int'(mc1), e.c1);
                chk("count_no_overlap", int'(mc0), e.c0);
`endif
                p1 = det1; p0 = det0;
            end else begin
                p1 = 1'b0; p0 = 1'b0;
            end
        end
    end

    initial begin
        int budget;
        rstn = 1'b1;
        seq  = 1'b0;
        model_reset();
        #1 rstn = 1'b0;
        #1;
        chk("reset_state_ov", int'(det1), 0);
        chk("reset_state_nov", int'(det0), 0);

        // Reset held two cycles with seq toggling.
        do_reset(2);

        // Mixed stream: 3 pulses with overlap, 2 without.
        drive_str("01101011011011");
        drive_str("0000");
        do_reset(1);
        drive_str("101011");     // S101 -> S10 on a 0
        do_reset(1);
        drive_str("111011");
        do_reset(1);

        // Partial progress discarded by reset.
        drive_str("101");
        do_reset(2);
        drive_str("1000");

        // Asynchronous reset between edges kills a live pulse.
        do_reset(1);
        drive_str("1011");
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_drop_ov", int'(det1), 0);
        chk("async_drop_nov", int'(det0), 0);
`ifdef SEQ_DET_COUNT_EN
        chk("async_cnt_clear", int'(mc1), 0);
`endif
        do_reset(2);

        // Five back-to-back 1011 groups: counter saturates, then clears on reset.
        drive_str("10111011101110111011");
        drive_str("00");
        do_reset(2);
        drive_str("0000");

        // Randomised stream, biased toward 1 at times, with sparse resets.
        for (int i = 0; i < 3000; i++) begin
            bit b;
            b = ((i / 200) % 2 == 1) ? ($urandom_range(0, 3) != 0) : bit'($urandom_range(0, 1));
            drive_bit(b, $urandom_range(0, 99) != 0);
        end
        drive_str("0000");

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
